// File: rtl/ariane_pkg.sv
// Shared frontend types: resolved-branch update and prediction records, plus BTB sizing defaults.
package ariane_pkg;

  localparam int unsigned BTB_SETS     = 64;
  localparam int unsigned BTB_WAYS     = 4;
  localparam int unsigned BTB_TAG_BITS = 16;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_taken;
    logic        is_lower_16;
    logic        clear;
  } branchpredict_t;

  typedef struct packed {
    logic        valid;
    logic        predict_taken;
    logic [63:0] predict_address;
    logic        is_lower_16;
  } branchpredict_sbe_t;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: next tree state after touching a way, and the current victim.
module plru_tree #(
  parameter int unsigned NR_WAYS = 4,
  localparam int unsigned WayW  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1,
  localparam int unsigned TreeW = (NR_WAYS > 1) ? NR_WAYS - 1 : 1
) (
  input  logic [TreeW-1:0] tree,
  input  logic [WayW-1:0]  touch_way,
  output logic [TreeW-1:0] next_tree,
  output logic [WayW-1:0]  victim
);

  if (NR_WAYS == 1) begin : g_single
    logic unused_touch;
    assign unused_touch = ^touch_way;
    assign next_tree    = tree;
    assign victim       = '0;
  end else begin : g_tree
    localparam int unsigned Lvls = $clog2(NR_WAYS);

    // Node (l, p) lies on the path of a way whose top l index bits equal p.
    // A touched node is set to point away from the accessed subtree.
    always_comb begin
      next_tree = tree;
      for (int l = 0; l < int'(Lvls); l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((touch_way >> (int'(Lvls) - l)) == WayW'(p)) begin
            next_tree[(1 << l) - 1 + p] = ~touch_way[int'(Lvls) - 1 - l];
          end
        end
      end
    end

    // Walk from the root: bit 0 means the victim is in the left subtree.
    always_comb begin
      victim = '0;
      for (int l = 0; l < int'(Lvls); l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((victim >> (int'(Lvls) - l)) == WayW'(p)) begin
            victim[int'(Lvls) - 1 - l] = tree[(1 << l) - 1 + p];
          end
        end
      end
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative BTB with full tags, invalid-first/PLRU allocation and a multi-cycle
// flush sweep. Lookups are combinational against registered state; updates land next cycle.
module btb_set_assoc
  import ariane_pkg::*;
#(
  parameter int unsigned NR_SETS                 = BTB_SETS,
  parameter int unsigned NR_WAYS                 = BTB_WAYS,
  parameter int unsigned TAG_BITS                = BTB_TAG_BITS,
  parameter int unsigned BITS_SATURATION_COUNTER = 2,
  parameter int unsigned OFFSET                  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [63:0]        vpc_i,
  input  branchpredict_t     branch_predict_i,
  output branchpredict_sbe_t branch_predict_o,
  output logic               flush_busy_o
);

  localparam int unsigned IDX   = $clog2(NR_SETS);
  localparam int unsigned WayW  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int unsigned TreeW = (NR_WAYS > 1) ? NR_WAYS - 1 : 1;
  localparam int unsigned B     = BITS_SATURATION_COUNTER;

  localparam logic [B-1:0]   CntWeakT   = B'(1) << (B - 1);
  localparam logic [B-1:0]   CntWeakNt  = CntWeakT - B'(1);
  localparam logic [IDX-1:0] LastSet    = IDX'(NR_SETS - 1);

  if ((NR_SETS < 2) || ((NR_SETS & (NR_SETS - 1)) != 0)) begin : g_chk_sets
    $error("btb_set_assoc: NR_SETS must be a power of two >= 2");
  end
  if ((NR_WAYS < 1) || ((NR_WAYS & (NR_WAYS - 1)) != 0)) begin : g_chk_ways
    $error("btb_set_assoc: NR_WAYS must be a power of two >= 1");
  end
  if ((OFFSET + IDX + TAG_BITS) > 64) begin : g_chk_addr
    $error("btb_set_assoc: OFFSET + log2(NR_SETS) + TAG_BITS exceeds 64");
  end
  if (B < 1) begin : g_chk_cnt
    $error("btb_set_assoc: BITS_SATURATION_COUNTER must be >= 1");
  end

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [63:0]         target;
    logic                is_lower_16;
    logic [B-1:0]        cnt;
  } btb_entry_t;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  btb_entry_t       btb_q  [NR_SETS][NR_WAYS];
  logic [TreeW-1:0] plru_q [NR_SETS];
  state_e           state_q;
  logic [IDX-1:0]   sweep_q;

  // ---------------------------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------------------------
  logic [IDX-1:0]      lu_set;
  logic [TAG_BITS-1:0] lu_tag;
  logic                lu_hit;
  logic [WayW-1:0]     lu_way;
  btb_entry_t          lu_entry;

  assign lu_set = vpc_i[OFFSET+IDX-1:OFFSET];
  assign lu_tag = vpc_i[OFFSET+IDX+TAG_BITS-1:OFFSET+IDX];

  always_comb begin
    lu_hit = 1'b0;
    lu_way = '0;
    for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
      if (btb_q[lu_set][w].valid && (btb_q[lu_set][w].tag == lu_tag)) begin
        lu_hit = 1'b1;
        lu_way = WayW'(w);
      end
    end
  end

  // On a miss lu_way stays 0, so the don't-care fields come from way 0.
  assign lu_entry = btb_q[lu_set][lu_way];

  always_comb begin
    branch_predict_o                 = '0;
    branch_predict_o.valid           = lu_hit && (state_q == StIdle) && !flush_i;
    branch_predict_o.predict_taken   = lu_entry.cnt[B-1];
    branch_predict_o.predict_address = lu_entry.target;
    branch_predict_o.is_lower_16     = lu_entry.is_lower_16;
  end

  assign flush_busy_o = (state_q == StSweep);

  // ---------------------------------------------------------------------------------------------
  // Update
  // ---------------------------------------------------------------------------------------------
  logic [IDX-1:0]      up_set;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_en;
  logic                up_hit;
  logic [WayW-1:0]     up_way;
  logic                inv_found;
  logic [WayW-1:0]     inv_way;
  logic [WayW-1:0]     plru_victim;
  logic [WayW-1:0]     touch_way;
  logic [TreeW-1:0]    plru_next;
  logic                wr_en;
  logic [WayW-1:0]     wr_way;
  btb_entry_t          wr_entry;
  logic                plru_we;
  logic                unused_pc_bits;

  assign up_set = branch_predict_i.pc[OFFSET+IDX-1:OFFSET];
  assign up_tag = branch_predict_i.pc[OFFSET+IDX+TAG_BITS-1:OFFSET+IDX];
  assign up_en  = branch_predict_i.valid && (state_q == StIdle) && !flush_i;

  assign unused_pc_bits = ^{vpc_i, branch_predict_i.pc};

  always_comb begin
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
      if (btb_q[up_set][w].valid && (btb_q[up_set][w].tag == up_tag)) begin
        up_hit = 1'b1;
        up_way = WayW'(w);
      end
      if (!btb_q[up_set][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
  end

  plru_tree #(
    .NR_WAYS (NR_WAYS)
  ) u_plru_tree (
    .tree      (plru_q[up_set]),
    .touch_way (touch_way),
    .next_tree (plru_next),
    .victim    (plru_victim)
  );

  always_comb begin
    wr_en     = 1'b0;
    wr_way    = up_way;
    wr_entry  = btb_q[up_set][up_way];
    plru_we   = 1'b0;
    touch_way = up_way;
    if (up_en) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (branch_predict_i.clear) begin
          wr_entry.valid = 1'b0;
        end else begin
          if (branch_predict_i.is_taken) begin
            if (wr_entry.cnt != {B{1'b1}}) wr_entry.cnt = wr_entry.cnt + B'(1);
          end else begin
            if (wr_entry.cnt != '0) wr_entry.cnt = wr_entry.cnt - B'(1);
          end
          wr_entry.target      = branch_predict_i.target_address;
          wr_entry.is_lower_16 = branch_predict_i.is_lower_16;
          plru_we              = (NR_WAYS > 1);
        end
      end else if (!branch_predict_i.clear) begin
        wr_en                = 1'b1;
        wr_way               = inv_found ? inv_way : plru_victim;
        touch_way            = wr_way;
        wr_entry.valid       = 1'b1;
        wr_entry.tag         = up_tag;
        wr_entry.target      = branch_predict_i.target_address;
        wr_entry.is_lower_16 = branch_predict_i.is_lower_16;
        wr_entry.cnt         = branch_predict_i.is_taken ? CntWeakT : CntWeakNt;
        plru_we              = (NR_WAYS > 1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State: entries, PLRU and flush FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btb_q  <= '{default: '0};
      plru_q <= '{default: '0};
    end else if (state_q == StSweep) begin
      for (int w = 0; w < int'(NR_WAYS); w++) begin
        btb_q[sweep_q][w].valid <= 1'b0;
        btb_q[sweep_q][w].cnt   <= '0;
      end
      plru_q[sweep_q] <= '0;
    end else begin
      if (wr_en)   btb_q[up_set][wr_way] <= wr_entry;
      if (plru_we) plru_q[up_set]        <= plru_next;
    end
  end

  // A flush in either state (re)starts the sweep from set 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sweep_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q <= StSweep;
            sweep_q <= '0;
          end
        end
        StSweep: begin
          if (flush_i) begin
            sweep_q <= '0;
          end else if (sweep_q == LastSet) begin
            state_q <= StIdle;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + IDX'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          sweep_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc with default parameters (set = pc[7:2], tag = pc[23:8]).
module tb_btb_set_assoc;
  import ariane_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic [63:0]        vpc_i;
  branchpredict_t     bp_in;
  branchpredict_sbe_t bp_out;
  logic               flush_busy_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    logic        v;
    logic        t;
    logic [63:0] a;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  btb_set_assoc #(
    .NR_SETS                 (64),
    .NR_WAYS                 (4),
    .TAG_BITS                (16),
    .BITS_SATURATION_COUNTER (2),
    .OFFSET                  (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .vpc_i            (vpc_i),
    .branch_predict_i (bp_in),
    .branch_predict_o (bp_out),
    .flush_busy_o     (flush_busy_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                            input logic clr);
    bp_in.valid          = 1'b1;
    bp_in.pc             = pc;
    bp_in.target_address = tgt;
    bp_in.is_taken       = taken;
    bp_in.is_lower_16    = pc[12];
    bp_in.clear          = clr;
  endtask

  task automatic update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                        input logic clr);
    set_update(pc, tgt, taken, clr);
    tick();
    bp_in.valid = 1'b0;
  endtask

  // Push the expected prediction, then compare when the DUT output settles at the falling edge.
  task automatic look(input string tag, input logic [63:0] pc, input logic v, input logic t,
                      input logic [63:0] a);
    exp_t e;
    vpc_i = pc;
    sb.push_back('{tag: tag, v: v, t: t, a: a});
    @(negedge clk_i);
    e = sb.pop_front();
    check_val({e.tag, "_valid"}, 64'(bp_out.valid), 64'(e.v));
    if (e.v) begin
      check_val({e.tag, "_taken"}, 64'(bp_out.predict_taken), 64'(e.t));
      check_val({e.tag, "_addr"}, bp_out.predict_address, e.a);
    end
  endtask

  task automatic sweep(input bit restart, output int cnt, output int vseen);
    cnt   = 0;
    vseen = 0;
    @(negedge clk_i);
    while (flush_busy_o === 1'b1 && cnt < 200) begin
      cnt++;
      if (bp_out.valid !== 1'b0) vseen++;
      if (cnt == 5) set_update(64'h7000, 64'h8000, 1'b1, 1'b0);
      if (cnt == 6) bp_in.valid = 1'b0;
      if (restart && cnt == 10) flush_i = 1'b1;
      if (restart && cnt == 11) flush_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int vseen;

    rst_ni  = 1'b0;
    flush_i = 1'b0;
    vpc_i   = '0;
    bp_in   = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // 1: reset state
    look("t1_reset", 64'h8000_0040, 1'b0, 1'b0, 64'h0);
    check_val("t1_busy", 64'(flush_busy_o), 64'h0);

    // 2: allocate, no same-cycle bypass, tag mismatch in same set
    tick();
    set_update(64'h1000, 64'h2000, 1'b1, 1'b0);
    look("t2_bypass", 64'h1000, 1'b0, 1'b0, 64'h0);
    tick();
    bp_in.valid = 1'b0;
    look("t2_hit", 64'h1000, 1'b1, 1'b1, 64'h2000);
    look("t2_alias", 64'h11000, 1'b0, 1'b0, 64'h0);

    // 3: fill set 0, then the PLRU victim is way 0
    update(64'h11000, 64'h12000, 1'b1, 1'b0);
    update(64'h21000, 64'h22000, 1'b1, 1'b0);
    update(64'h31000, 64'h32000, 1'b1, 1'b0);
    update(64'h41000, 64'h42000, 1'b1, 1'b0);
    look("t3_evicted", 64'h1000, 1'b0, 1'b0, 64'h0);
    look("t3_w1", 64'h11000, 1'b1, 1'b1, 64'h12000);
    look("t3_w2", 64'h21000, 1'b1, 1'b1, 64'h22000);
    look("t3_w3", 64'h31000, 1'b1, 1'b1, 64'h32000);
    look("t3_new", 64'h41000, 1'b1, 1'b1, 64'h42000);

    // 4: counter saturation (0x1000 replaces PLRU victim way 2 with counter 2)
    update(64'h1000, 64'h2000, 1'b1, 1'b0);
    look("t4_alloc", 64'h1000, 1'b1, 1'b1, 64'h2000);
    look("t4_w2_gone", 64'h21000, 1'b0, 1'b0, 64'h0);
    update(64'h1000, 64'h3000, 1'b0, 1'b0);
    look("t4_nt1", 64'h1000, 1'b1, 1'b0, 64'h3000);
    update(64'h1000, 64'h3000, 1'b0, 1'b0);
    look("t4_nt2", 64'h1000, 1'b1, 1'b0, 64'h3000);
    update(64'h1000, 64'h3000, 1'b0, 1'b0);
    look("t4_nt3", 64'h1000, 1'b1, 1'b0, 64'h3000);
    update(64'h1000, 64'h2000, 1'b1, 1'b0);
    look("t4_t1", 64'h1000, 1'b1, 1'b0, 64'h2000);
    update(64'h1000, 64'h2000, 1'b1, 1'b0);
    look("t4_t2", 64'h1000, 1'b1, 1'b1, 64'h2000);
    update(64'h1000, 64'h2000, 1'b1, 1'b0);
    update(64'h1000, 64'h2000, 1'b1, 1'b0);
    update(64'h1000, 64'h2400, 1'b0, 1'b0);
    look("t4_top_sat", 64'h1000, 1'b1, 1'b1, 64'h2400);

    // 5: clear on hit and on miss; next allocation reuses the invalid way
    update(64'h1000, 64'h0, 1'b0, 1'b1);
    look("t5_cleared", 64'h1000, 1'b0, 1'b0, 64'h0);
    update(64'h5000, 64'h6000, 1'b1, 1'b1);
    look("t5_clr_miss", 64'h5000, 1'b0, 1'b0, 64'h0);
    look("t5_other", 64'h41000, 1'b1, 1'b1, 64'h42000);
    update(64'h61000, 64'h62000, 1'b0, 1'b0);
    look("t5_weak_nt", 64'h61000, 1'b1, 1'b0, 64'h62000);
    look("t5_inv_first", 64'h11000, 1'b1, 1'b1, 64'h12000);

    // 6: flush with a simultaneous update, updates dropped during the sweep
    tick();
    flush_i = 1'b1;
    set_update(64'h9000, 64'hA000, 1'b1, 1'b0);
    look("t6_flush_cycle", 64'h41000, 1'b0, 1'b0, 64'h0);
    tick();
    flush_i     = 1'b0;
    bp_in.valid = 1'b0;
    sweep(1'b0, cnt, vseen);
    check_val("t6_busy_len", 64'(cnt), 64'd64);
    check_val("t6_valid_in_sweep", 64'(vseen), 64'd0);
    check_val("t6_busy_end", 64'(flush_busy_o), 64'h0);
    look("t6_miss_a", 64'h41000, 1'b0, 1'b0, 64'h0);
    look("t6_miss_b", 64'h11000, 1'b0, 1'b0, 64'h0);
    look("t6_miss_c", 64'h61000, 1'b0, 1'b0, 64'h0);
    look("t6_drop_sweep", 64'h7000, 1'b0, 1'b0, 64'h0);
    look("t6_drop_flush", 64'h9000, 1'b0, 1'b0, 64'h0);

    // 6b: restart the sweep in its 10th cycle
    update(64'h41000, 64'h42000, 1'b1, 1'b0);
    look("t6_refill", 64'h41000, 1'b1, 1'b1, 64'h42000);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sweep(1'b1, cnt, vseen);
    check_val("t6_restart_len", 64'(cnt), 64'd74);
    check_val("t6_restart_valid", 64'(vseen), 64'd0);
    look("t6_restart_miss", 64'h41000, 1'b0, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
